// File: rtl/serial_add_controller.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first,
// carry held in a flop between bits, result reported with a done pulse.
module bitAdder (
  input  logic A_in,
  input  logic B_in,
  input  logic Carry_in,
  output logic Sum_out,
  output logic Carry_out
);
  assign Sum_out   = A_in ^ B_in ^ Carry_in;
  assign Carry_out = (A_in & B_in) | (Carry_in & (A_in ^ B_in));
endmodule

module serial_add_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic             sub_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] Sum_out,
  output logic             Carry_out,
  output logic             Overflow_out
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] shifted;

  bitAdder u_cell (
    .A_in      (a_q[0]),
    .B_in      (b_q[0]),
    .Carry_in  (cy_q),
    .Sum_out   (cell_s),
    .Carry_out (cell_co)
  );

  assign shifted = {cell_s, res_q};

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d     = A_in;
          b_d     = sub_in ? ~B_in : B_in;
          cy_d    = sub_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = shifted[WIDTH-1:1];
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = cell_co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // cy_q is the carry into the MSB on this last bit
          sum_d   = shifted;
          carry_d = cell_co;
          ovf_d   = cy_q ^ cell_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_out     = (state_q != IDLE);
    done_out     = (state_q == DONE);
    Sum_out      = sum_q;
    Carry_out    = carry_q;
    Overflow_out = ovf_q;
  end
endmodule

// File: tb/tb_serial_add_controller.sv
// Directed bench for the bit-serial add/subtract sequencer (WIDTH=8).
module tb_serial_add_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, cy, ovf;
  logic [7:0] sum;
  int errors = 0;
  int checks = 0;

  serial_add_controller #(.WIDTH(8)) dut (
    .clk_in       (clk),
    .reset_in     (rst),
    .start_in     (start),
    .sub_in       (sub),
    .A_in         (a),
    .B_in         (b),
    .busy_out     (busy),
    .done_out     (done),
    .Sum_out      (sum),
    .Carry_out    (cy),
    .Overflow_out (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({busy, done, sum, cy, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got=%h want=000", {busy, done, sum, cy, ovf});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got=%b want=00", {busy, done});
    end
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic is, input logic [7:0] es,
                        input logic ec, input logic ev, input string nm);
    int n;
    a = ia; b = ib; sub = is; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ia; b = ~ib; sub = ~is;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy got=%b want=1", nm, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s_latency got=%0d want=8", nm, n);
    end
    checks++;
    if ({sum, cy, ovf} !== {es, ec, ev}) begin
      errors++;
      $display("FAIL %s_result got=%h/%b/%b want=%h/%b/%b",
               nm, sum, cy, ovf, es, ec, ev);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_idle got=%b want=00", nm, {busy, done});
    end
  endtask

  task automatic test_add();
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1, "add_7f_7f");
  endtask

  task automatic test_sub();
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
  endtask

  task automatic test_ignore_busy();
    int n;
    int extra;
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (sum !== 8'h7F) begin
      errors++;
      $display("FAIL hold_prev got=%h want=7f", sum);
    end
    n = 3;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8 || {sum, cy, ovf} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result got=%h/%b/%b n=%0d want=02/0/0 n=8",
               sum, cy, ovf, n);
    end
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_extra got=%0d want=0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, cy, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got=%h want=000", {busy, done, sum, cy, ovf});
    end
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done got=%0d want=0", seen);
    end
    run_op(8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    int last;
    int pulses;
    int bad_gap;
    int bad_sum;
    a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
    last = -1; pulses = 0; bad_gap = 0; bad_sum = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin
        if (last >= 0 && k - last != 10) bad_gap++;
        last = k;
        pulses++;
      end
      if (pulses > 0 && sum !== 8'h96) bad_sum++;
    end
    start = 1'b0;
    checks++;
    if (pulses != 4 || bad_gap != 0) begin
      errors++;
      $display("FAIL b2b_rate got=%0d pulses %0d bad gaps want=4 pulses 0",
               pulses, bad_gap);
    end
    checks++;
    if (bad_sum != 0) begin
      errors++;
      $display("FAIL b2b_stable got=%0d unstable want=0", bad_sum);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got=%b want=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
